vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Upstream timing stage for the Ultra96 PMOD VGA path.
- Derives a pixel clock-enable from the fabric clock and runs horizontal/vertical raster counters.
- Produces registered, mutually aligned hcnt/vcnt/hs/vs/de plus line and frame strobes, which the pixel painter consumes to draw.
- Replaces the per-painter divided-clock and counter logic with one single-clock, enable-based generator.

Parameters:
CLK_DIV, 2, clk cycles per pixel; legal range 1..16
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hs active level (0 = active low)
VS_POL, 0, vs active level (0 = active low)

Ports:
clk  in  1  single system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
pix_ce  out  1  one-clk pulse; marks cycles on which raster outputs update
hcnt  out  10  horizontal position, 0..H_TOTAL-1
vcnt  out  10  vertical position, 0..V_TOTAL-1
hs  out  1  horizontal sync, level per HS_POL
vs  out  1  vertical sync, level per VS_POL
de  out  1  display enable; high when hcnt<H_ACTIVE and vcnt<V_ACTIVE
line_start  out  1  one-clk pulse when hcnt becomes 0
frame_start  out  1  one-clk pulse when (hcnt,vcnt) becomes (0,0)
frame_cnt  out  8  frame counter, increments with frame_start, wraps 255->0
rgb  out  12  test-pattern colour {R4,G4,B4}; see Optional Feature

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. No other clocks and no async reset.
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525). Both must be ≤1024; violations are elaboration errors.
- Divider: div counts 0..CLK_DIV-1. pix_ce is registered and is high for the one clk in which div==CLK_DIV-1. With CLK_DIV=1, pix_ce is constantly 1 after reset.
- Reset values: div=0, pix_ce=0, hcnt=H_TOTAL-1, vcnt=V_TOTAL-1, hs=!HS_POL, vs=!VS_POL, de=0, line_start=0, frame_start=0, frame_cnt=0, rgb=0.
- First pix_ce comes on the CLK_DIV-th clk after rst deasserts. That pix_ce wraps the counters to (0,0) with de=1, line_start=1, frame_start=1, frame_cnt=1.
- On each pix_ce, all raster outputs update together in that same clk edge:
  - hcnt increments; at H_TOTAL-1 it wraps to 0 and vcnt increments.
  - vcnt wraps V_TOTAL-1 -> 0 only on an hcnt wrap.
- hs/vs/de are decoded from the *next* counter values and registered. They are therefore always consistent with the hcnt/vcnt presented on the same cycle, with zero skew.
  - hs active for H_ACTIVE+H_FP ≤ hcnt < H_ACTIVE+H_FP+H_SYNC (default 656..751).
  - vs active for V_ACTIVE+V_FP ≤ vcnt < V_ACTIVE+V_FP+V_SYNC (default 490..491); vs is line-based and does not depend on hcnt.
- line_start and frame_start are high only in the clk where pix_ce=1 and the new hcnt==0 (and vcnt==0 for frame_start). They are 0 in all other clks.
- Between pix_ce pulses, all raster outputs hold.
- rst asserted mid-frame: on the next edge every output returns to its reset value, regardless of div phase. The restart sequence is identical to power-up.
- Consumer latency contract: colour computed from hcnt/vcnt/de in the pix_ce cycle and registered on the next pix_ce lags hs/vs by one pixel. The painter must delay hs/vs by one pix_ce to match.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined: rgb carries 8 vertical colour bars, each H_ACTIVE/8 pixels wide (80 by default).
  - Order: fff, ff0, 0ff, 0f0, f0f, f00, 00f, 000.
  - Bar index comes from an internal bar counter, with no divider: it resets at hcnt=0 and steps every H_ACTIVE/8 pixels.
  - rgb is registered with the same timing as de and is 000 whenever the registered de=0.
- Undefined: rgb is tied to 12'h000 and the bar logic is absent.

Test Plan:
- Reset release, defaults (CLK_DIV=2) -> first pix_ce on clk 2; same clk shows hcnt=0, vcnt=0, de=1, frame_start=1, line_start=1, frame_cnt=1.
- Free-run one line -> line_start period 1600 clk; hs low for exactly 96 pix_ce (hcnt 656..751); de high for hcnt 0..639 only.
- Free-run 3 frames -> frame_start period 840000 clk; vs low only for vcnt 490 and 491 (2 lines = 3200 clk); frame_cnt steps 1,2,3.
- Assert rst for 1 clk at hcnt=300, vcnt=200, div=1 -> next clk shows reset values; restart matches power-up, first pix_ce 2 clk after release.
- CLK_DIV=1, HS_POL=1 -> pix_ce constant 1; line period 800 clk; hs high for hcnt 656..751.
- VGA_TEST_PATTERN_EN defined -> rgb=fff at hcnt 0..79, ff0 at hcnt 80, 000 at hcnt 560..639 and at hcnt 700; no macro -> rgb always 000.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Raster bundle from the VGA timing generator to the pixel painter.
// All fields are registered and mutually aligned at the generator.
interface vga_timing_gen_if;
    logic        pix_ce;
    logic [9:0]  hcnt;
    logic [9:0]  vcnt;
    logic        hs;
    logic        vs;
    logic        de;
    logic        line_start;
    logic        frame_start;
    logic [7:0]  frame_cnt;
    logic [11:0] rgb;

    modport master (
        output pix_ce,
        output hcnt,
        output vcnt,
        output hs,
        output vs,
        output de,
        output line_start,
        output frame_start,
        output frame_cnt,
        output rgb
    );

    modport slave (
        input pix_ce,
        input hcnt,
        input vcnt,
        input hs,
        input vs,
        input de,
        input line_start,
        input frame_start,
        input frame_cnt,
        input rgb
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Single-clock VGA raster generator: pixel clock-enable plus h/v counters.
// Define VGA_TEST_PATTERN_EN to drive 8 vertical colour bars on rgb.
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0
) (
    input logic              clk,
    input logic              rst,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = V_ACTIVE + V_FP + V_SYNC;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic       HS_ON    = (HS_POL != 0);
    localparam logic       VS_ON    = (VS_POL != 0);

    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be 1..16");
    end
    if (H_TOTAL > 1024) begin : g_bad_h
        $error("vga_timing_gen: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > 1024) begin : g_bad_v
        $error("vga_timing_gen: V_TOTAL exceeds 1024");
    end

    logic [3:0]  div;
    logic        tick;
    logic        pix_ce_q;
    logic [9:0]  hcnt_q;
    logic [9:0]  vcnt_q;
    logic        hs_q;
    logic        vs_q;
    logic        de_q;
    logic        line_q;
    logic        frame_q;
    logic [7:0]  fcnt_q;
    logic [11:0] rgb_q;

    logic [9:0]  h_nxt;
    logic [9:0]  v_nxt;
    logic        hs_act;
    logic        vs_act;
    logic        de_nxt;
    logic        line_nxt;
    logic        frame_nxt;

    // tick marks the edge on which the raster advances; pix_ce mirrors it
    assign tick = (div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            div      <= '0;
            pix_ce_q <= 1'b0;
        end else begin
            pix_ce_q <= tick;
            div      <= tick ? '0 : div + 4'd1;
        end
    end

    // sync/enable decode uses the next counter values so they land with them
    always_comb begin
        h_nxt = hcnt_q + 10'd1;
        v_nxt = vcnt_q;
        if (hcnt_q == H_LAST) begin
            h_nxt = '0;
            v_nxt = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
        end
        hs_act    = (int'(h_nxt) >= HS_BEG) && (int'(h_nxt) < HS_END);
        vs_act    = (int'(v_nxt) >= VS_BEG) && (int'(v_nxt) < VS_END);
        de_nxt    = (int'(h_nxt) < H_ACTIVE) && (int'(v_nxt) < V_ACTIVE);
        line_nxt  = (h_nxt == '0);
        frame_nxt = line_nxt && (v_nxt == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q  <= H_LAST;
            vcnt_q  <= V_LAST;
            hs_q    <= !HS_ON;
            vs_q    <= !VS_ON;
            de_q    <= 1'b0;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            line_q  <= tick && line_nxt;
            frame_q <= tick && frame_nxt;
            if (tick) begin
                hcnt_q <= h_nxt;
                vcnt_q <= v_nxt;
                hs_q   <= hs_act ? HS_ON : !HS_ON;
                vs_q   <= vs_act ? VS_ON : !VS_ON;
                de_q   <= de_nxt;
                if (frame_nxt) begin
                    fcnt_q <= fcnt_q + 8'd1;
                end
            end
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam int         BAR_W    = H_ACTIVE / 8;
    localparam logic [9:0] BAR_LAST = 10'(BAR_W - 1);

    if (BAR_W < 1) begin : g_bad_bar
        $error("vga_timing_gen: H_ACTIVE too small for 8 bars");
    end

    logic [9:0]  bar_px;
    logic [2:0]  bar_idx;
    logic [9:0]  bar_px_nxt;
    logic [2:0]  bar_idx_nxt;
    logic [11:0] bar_rgb;

    // bar position tracks the next pixel, so colour aligns with de
    always_comb begin
        bar_px_nxt  = bar_px + 10'd1;
        bar_idx_nxt = bar_idx;
        if (h_nxt == '0) begin
            bar_px_nxt  = '0;
            bar_idx_nxt = '0;
        end else if (bar_px == BAR_LAST) begin
            bar_px_nxt  = '0;
            bar_idx_nxt = bar_idx + 3'd1;
        end
    end

    always_comb begin
        bar_rgb = 12'h000;
        unique case (bar_idx_nxt)
            3'd0: bar_rgb = 12'hfff;
            3'd1: bar_rgb = 12'hff0;
            3'd2: bar_rgb = 12'h0ff;
            3'd3: bar_rgb = 12'h0f0;
            3'd4: bar_rgb = 12'hf0f;
            3'd5: bar_rgb = 12'hf00;
            3'd6: bar_rgb = 12'h00f;
            3'd7: bar_rgb = 12'h000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bar_px  <= '0;
            bar_idx <= '0;
            rgb_q   <= '0;
        end else if (tick) begin
            bar_px  <= bar_px_nxt;
            bar_idx <= bar_idx_nxt;
            rgb_q   <= de_nxt ? bar_rgb : 12'h000;
        end
    end
`else
    assign rgb_q = 12'h000;
`endif

    assign vga.pix_ce      = pix_ce_q;
    assign vga.hcnt        = hcnt_q;
    assign vga.vcnt        = vcnt_q;
    assign vga.hs          = hs_q;
    assign vga.vs          = vs_q;
    assign vga.de          = de_q;
    assign vga.line_start  = line_q;
    assign vga.frame_start = frame_q;
    assign vga.frame_cnt   = fcnt_q;
    assign vga.rgb         = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default, tiny-raster and CLK_DIV=1 builds.
// Expected rasters are computed from clk index after reset release.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if vif_d ();
    vga_timing_gen_if vif_s ();
    vga_timing_gen_if vif_o ();

    vga_timing_gen u_d (
        .clk (clk),
        .rst (rst),
        .vga (vif_d)
    );

    // tiny raster: 12 x 8, hs at 9..10, vs at 5..6
    vga_timing_gen #(
        .CLK_DIV (2),
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_s (
        .clk (clk),
        .rst (rst),
        .vga (vif_s)
    );

    vga_timing_gen #(
        .CLK_DIV(1),
        .HS_POL (1)
    ) u_o (
        .clk (clk),
        .rst (rst),
        .vga (vif_o)
    );

    logic [33:0] obs_d;
    logic [33:0] obs_s;
    logic [33:0] obs_o;

    assign obs_d = {vif_d.pix_ce, vif_d.hcnt, vif_d.vcnt, vif_d.hs, vif_d.vs,
                    vif_d.de, vif_d.line_start, vif_d.frame_start, vif_d.frame_cnt};
    assign obs_s = {vif_s.pix_ce, vif_s.hcnt, vif_s.vcnt, vif_s.hs, vif_s.vs,
                    vif_s.de, vif_s.line_start, vif_s.frame_start, vif_s.frame_cnt};
    assign obs_o = {vif_o.pix_ce, vif_o.hcnt, vif_o.vcnt, vif_o.hs, vif_o.vs,
                    vif_o.de, vif_o.line_start, vif_o.frame_start, vif_o.frame_cnt};

    function automatic logic [33:0] pk(logic pce, int h, int v, logic hs,
                                       logic vs, logic de, logic ls,
                                       logic fs, int fc);
        return {pce, 10'(h), 10'(v), hs, vs, de, ls, fs, 8'(fc)};
    endfunction

    function automatic logic [11:0] bar_exp(int h);
        logic [11:0] bars [8];
        bars = '{12'hfff, 12'hff0, 12'h0ff, 12'h0f0,
                 12'hf0f, 12'hf00, 12'h00f, 12'h000};
        if (h < 640) return bars[h / 80];
        return 12'h000;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [33:0] e;
        rst = 1'b1;
        step();
        step();
        e = pk(0, 799, 524, 1, 1, 0, 0, 0, 0);
        vectors++;
        if (obs_d !== e) begin
            miscompares++;
            $display("FAIL reset_d got %h want %h", obs_d, e);
        end
        e = pk(0, 11, 7, 1, 1, 0, 0, 0, 0);
        vectors++;
        if (obs_s !== e) begin
            miscompares++;
            $display("FAIL reset_s got %h want %h", obs_s, e);
        end
        e = pk(0, 799, 524, 0, 1, 0, 0, 0, 0);
        vectors++;
        if (obs_o !== e) begin
            miscompares++;
            $display("FAIL reset_o got %h want %h", obs_o, e);
        end
        vectors++;
        if ((vif_d.rgb | vif_s.rgb | vif_o.rgb) !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_rgb got %h want 000",
                     vif_d.rgb | vif_s.rgb | vif_o.rgb);
        end
        rst = 1'b0;
        step();
        e = pk(0, 799, 524, 1, 1, 0, 0, 0, 0);
        vectors++;
        if (obs_d !== e) begin
            miscompares++;
            $display("FAIL clk1_d got %h want %h", obs_d, e);
        end
        e = pk(1, 0, 0, 0, 1, 1, 1, 1, 1);
        vectors++;
        if (obs_o !== e) begin
            miscompares++;
            $display("FAIL clk1_o got %h want %h", obs_o, e);
        end
        step();
        e = pk(1, 0, 0, 1, 1, 1, 1, 1, 1);
        vectors++;
        if (obs_d !== e) begin
            miscompares++;
            $display("FAIL clk2_d got %h want %h", obs_d, e);
        end
        vectors++;
        if (obs_s !== e) begin
            miscompares++;
            $display("FAIL clk2_s got %h want %h", obs_s, e);
        end
        e = pk(1, 1, 0, 0, 1, 1, 0, 0, 1);
        vectors++;
        if (obs_o !== e) begin
            miscompares++;
            $display("FAIL clk2_o got %h want %h", obs_o, e);
        end
        step();
        e = pk(0, 0, 0, 1, 1, 1, 0, 0, 1);
        vectors++;
        if (obs_d !== e) begin
            miscompares++;
            $display("FAIL clk3_d got %h want %h", obs_d, e);
        end
    endtask

    task automatic test_line();
        logic [33:0] e;
        logic        pce;
        int          p, eh, ev, last, hs_low;
        do_reset();
        last   = 0;
        hs_low = 0;
        for (int c = 1; c <= 3300; c++) begin
            step();
            pce = (c >= 2) && (c % 2 == 0);
            p   = (c < 2) ? -1 : (c - 2) / 2;
            eh  = (p < 0) ? 799 : p % 800;
            ev  = (p < 0) ? 524 : p / 800;
            e   = pk(pce, eh, ev, !(eh >= 656 && eh < 752), 1,
                     (eh < 640 && ev < 480), pce && eh == 0,
                     pce && eh == 0 && ev == 0, (p < 0) ? 0 : 1);
            vectors++;
            if (obs_d !== e) begin
                miscompares++;
                $display("FAIL line c=%0d got %h want %h", c, obs_d, e);
            end
            if (vif_d.pix_ce && !vif_d.hs) hs_low++;
            if (vif_d.line_start) begin
                if (last > 0) begin
                    vectors++;
                    if (c - last != 1600) begin
                        miscompares++;
                        $display("FAIL line_period got %0d want 1600", c - last);
                    end
                    vectors++;
                    if (hs_low != 96) begin
                        miscompares++;
                        $display("FAIL hs_width got %0d want 96", hs_low);
                    end
                end
                last   = c;
                hs_low = 0;
            end
        end
    endtask

    task automatic test_frames();
        logic [33:0] e;
        logic        pce;
        int          p, eh, ev, fr, last, vs_low;
        do_reset();
        last   = 0;
        vs_low = 0;
        for (int c = 1; c <= 583; c++) begin
            step();
            pce = (c >= 2) && (c % 2 == 0);
            p   = (c < 2) ? -1 : (c - 2) / 2;
            eh  = (p < 0) ? 11 : p % 12;
            ev  = (p < 0) ? 7 : (p / 12) % 8;
            fr  = (p < 0) ? 0 : (p / 96 + 1) % 256;
            e   = pk(pce, eh, ev, !(eh >= 9 && eh < 11),
                     !(ev >= 5 && ev < 7), (eh < 8 && ev < 4),
                     pce && eh == 0, pce && eh == 0 && ev == 0, fr);
            vectors++;
            if (obs_s !== e) begin
                miscompares++;
                $display("FAIL frame c=%0d got %h want %h", c, obs_s, e);
            end
            if (vif_s.frame_start) begin
                if (last > 0) begin
                    vectors++;
                    if (c - last != 192) begin
                        miscompares++;
                        $display("FAIL frame_period got %0d want 192", c - last);
                    end
                    vectors++;
                    if (vs_low != 48) begin
                        miscompares++;
                        $display("FAIL vs_width got %0d want 48", vs_low);
                    end
                end
                last   = c;
                vs_low = 0;
            end
            if (!vif_s.vs) vs_low++;
        end
        for (int c = 584; c <= 48961; c++) step();
        vectors++;
        if ({vif_s.frame_start, vif_s.frame_cnt} !== {1'b0, 8'd255}) begin
            miscompares++;
            $display("FAIL fcnt_255 got %0d/%0d want 0/255",
                     vif_s.frame_start, vif_s.frame_cnt);
        end
        step();
        vectors++;
        if ({vif_s.frame_start, vif_s.frame_cnt} !== {1'b1, 8'd0}) begin
            miscompares++;
            $display("FAIL fcnt_wrap got %0d/%0d want 1/0",
                     vif_s.frame_start, vif_s.frame_cnt);
        end
    endtask

    task automatic test_midreset();
        logic [33:0] e;
        do_reset();
        for (int c = 1; c <= 101; c++) step();
        e = pk(0, 1, 4, 1, 1, 0, 0, 0, 1);
        vectors++;
        if (obs_s !== e) begin
            miscompares++;
            $display("FAIL pre_rst got %h want %h", obs_s, e);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        e = pk(0, 11, 7, 1, 1, 0, 0, 0, 0);
        vectors++;
        if ({obs_s, vif_s.rgb} !== {e, 12'h000}) begin
            miscompares++;
            $display("FAIL mid_rst got %h want %h", {obs_s, vif_s.rgb}, {e, 12'h000});
        end
        step();
        vectors++;
        if (obs_s !== e) begin
            miscompares++;
            $display("FAIL mid_rst_clk1 got %h want %h", obs_s, e);
        end
        step();
        e = pk(1, 0, 0, 1, 1, 1, 1, 1, 1);
        vectors++;
        if (obs_s !== e) begin
            miscompares++;
            $display("FAIL mid_rst_clk2 got %h want %h", obs_s, e);
        end
    endtask

    task automatic test_div1();
        logic [33:0] e;
        int          eh, ev, last;
        do_reset();
        last = 0;
        for (int c = 1; c <= 1700; c++) begin
            step();
            eh = (c - 1) % 800;
            ev = (c - 1) / 800;
            e  = pk(1, eh, ev, (eh >= 656 && eh < 752), 1, eh < 640,
                    eh == 0, eh == 0 && ev == 0, 1);
            vectors++;
            if (obs_o !== e) begin
                miscompares++;
                $display("FAIL div1 c=%0d got %h want %h", c, obs_o, e);
            end
            if (vif_o.line_start) begin
                if (last > 0) begin
                    vectors++;
                    if (c - last != 800) begin
                        miscompares++;
                        $display("FAIL div1_period got %0d want 800", c - last);
                    end
                end
                last = c;
            end
        end
    endtask

    task automatic test_pattern();
        logic [11:0] er;
        int          eh;
        do_reset();
        for (int c = 1; c <= 1602; c++) begin
            step();
            eh = (c < 2) ? 799 : ((c - 2) / 2) % 800;
            er = 12'h000;
`ifdef VGA_TEST_PATTERN_EN
            if (c >= 2) er = bar_exp(eh);
`endif
            vectors++;
            if (vif_d.rgb !== er) begin
                miscompares++;
                $display("FAIL rgb c=%0d h=%0d got %h want %h",
                         c, eh, vif_d.rgb, er);
            end
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_frames();
        test_midreset();
        test_div1();
        test_pattern();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
